seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector: the successor to the fixed 4-state "1010" Mealy detector. Adds a runtime-programmable pattern and length, a selectable overlap/non-overlap mode, input qualification, a registered copy of the match, and a saturating match counter. Sits on a serial bit stream, in front of framing/sync logic that needs a combinational same-cycle match flag.

---
 rtl/seq_detector_param.sv | 73 +++++++
 tb/tb_seq_detector_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a programmable pattern and length, overlap control,
// a combinational Mealy match, a registered match copy and a saturating match counter.
module seq_detector_param #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int             CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in,
  input  logic                         overlap,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  output logic                         match,
  output logic                         match_q,
  output logic [CNT_W-1:0]             match_cnt
);
  localparam int LW = $clog2(PAT_W+1);

  logic [PAT_W-2:0] hist;
  logic [LW-1:0]    fill, len, len_n;
  logic [PAT_W-1:0] pat, cand, mask;
  logic             hit;

  always_comb begin
    cand = {hist, in};
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      if (LW'(i) < len) mask[i] = 1'b1;
    hit = in_valid & ~cfg_load & rst & (fill >= len - 1'b1) &
          (((cand ^ pat) & mask) == '0);
  end

  // Programmed length is clamped into 1..PAT_W so the mask is never empty.
  always_comb begin
    len_n = cfg_len;
    if (cfg_len == '0)               len_n = LW'(1);
    else if (cfg_len > LW'(PAT_W))   len_n = LW'(PAT_W);
  end

  assign match = hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat       <= PATTERN;
      len       <= LW'(PAT_W);
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      match_cnt <= '0;
    end else begin
      match_q <= hit;
      if (hit && !(&match_cnt)) match_cnt <= match_cnt + 1'b1;
      if (cfg_load) begin
        pat  <= cfg_pattern;
        len  <= len_n;
        hist <= '0;
        fill <= '0;
      end else if (in_valid) begin
        if (hit && !overlap) begin
          // non-overlapping: the matched bits are consumed
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= cand[PAT_W-2:0];
          if (fill != LW'(PAT_W-1)) fill <= fill + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic against a
// queue-based reference model; a second instance uses a 2-bit counter for saturation.
module tb_seq_detector_param;
  localparam int PAT_W = 4;
  localparam int LW    = 3;

  logic clk = 0, rst = 0, in_valid = 0, in = 0, overlap = 1, cfg_load = 0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LW-1:0]    cfg_len = '0;
  logic match, match_q, match2, match_q2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .match(match), .match_q(match_q), .match_cnt(match_cnt));

  seq_detector_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .match(match2), .match_q(match_q2), .match_cnt(match_cnt2));

  // reference model: accepted bits since last clear, oldest at front
  bit        q[$];
  bit [3:0]  m_pat = 4'b1010;
  int        m_len = 4;
  int        m_cnt = 0, m_cnt2 = 0;
  bit        m_prev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(bit v, bit b, bit cl, bit r);
    bit x;
    if (!v || cl || !r) return 0;
    if (q.size() < m_len - 1) return 0;
    for (int k = 0; k < m_len; k++) begin
      x = (k == 0) ? b : q[q.size() - k];
      if (x != m_pat[k]) return 0;
    end
    return 1;
  endfunction

  task automatic step(input bit v, input bit b, input bit ov, input bit cl,
                      input logic [3:0] cp, input logic [2:0] clen, input bit r);
    bit h;
    @(negedge clk);
    in_valid = v; in = b; overlap = ov; cfg_load = cl;
    cfg_pattern = cp; cfg_len = clen; rst = r;
    #1;
    h = model_hit(v, b, cl, r);
    chk("match", {31'd0, match}, {31'd0, h});
    chk("match2", {31'd0, match2}, {31'd0, h});
    @(posedge clk);
    if (!r) begin
      q.delete(); m_pat = 4'b1010; m_len = 4; m_cnt = 0; m_cnt2 = 0; m_prev = 0;
    end else begin
      m_prev = h;
      if (h) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (cl) begin
        m_pat = cp;
        m_len = (clen == 0) ? 1 : (clen > PAT_W) ? PAT_W : int'(clen);
        q.delete();
      end else if (v) begin
        if (h && !ov) q.delete();
        else begin
          q.push_back(b);
          if (q.size() > PAT_W - 1) void'(q.pop_front());
        end
      end
    end
    #1;
    chk("match_q", {31'd0, match_q}, {31'd0, m_prev});
    chk("match_q2", {31'd0, match_q2}, {31'd0, m_prev});
    chk("match_cnt", {24'd0, match_cnt}, m_cnt);
    chk("match_cnt2", {30'd0, match_cnt2}, m_cnt2);
  endtask

  task automatic bitin(input bit b, input bit ov);
    step(1, b, ov, 0, 4'd0, 3'd0, 1);
  endtask
  task automatic idle();
    step(0, 0, 1, 0, 4'd0, 3'd0, 1);
  endtask
  task automatic do_reset();
    step(0, 0, 1, 0, 4'd0, 3'd0, 0);
  endtask
  task automatic cfg(input logic [3:0] cp, input logic [2:0] clen);
    step(1, 1, 1, 1, cp, clen, 1);
  endtask
  task automatic stream(input logic [15:0] bits, input int n, input bit ov, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      bitin(bits[i], ov);
      if (i != 0) for (int g = 0; g < gap; g++) idle();
    end
  endtask

  initial begin
    do_reset(); do_reset();
    chk("rst_match_q", {31'd0, match_q}, 32'd0);
    chk("rst_cnt", {24'd0, match_cnt}, 32'd0);

    // default 1010, overlapping
    stream(16'b101010, 6, 1, 0);
    chk("ovl_cnt", {24'd0, match_cnt}, 32'd2);

    // non-overlapping
    do_reset();
    stream(16'b101010, 6, 0, 0);
    chk("novl_cnt", {24'd0, match_cnt}, 32'd1);

    // gaps are transparent
    do_reset();
    stream(16'b1010, 4, 1, 3);
    chk("gap_cnt", {24'd0, match_cnt}, 32'd1);

    // programmed 3-bit pattern 110
    do_reset();
    cfg(4'b0110, 3'd3);
    stream(16'b110110, 6, 1, 0);
    chk("cfg3_cnt", {24'd0, match_cnt}, 32'd2);
    cfg(4'b0110, 3'd0);
    stream(16'b0010, 4, 1, 0);
    chk("len0_cnt", {24'd0, match_cnt}, 32'd5);
    cfg(4'b1010, 3'd7);
    stream(16'b1011010, 7, 1, 0);
    chk("len7_cnt", {24'd0, match_cnt}, 32'd6);

    // saturation of the 2-bit counter with len=1
    do_reset();
    cfg(4'b0001, 3'd1);
    stream(16'b1111111, 7, 1, 0);
    chk("sat_cnt2", {30'd0, match_cnt2}, 32'd3);
    chk("sat_cnt", {24'd0, match_cnt}, 32'd7);

    // reset mid-stream discards progress
    do_reset();
    stream(16'b101, 3, 1, 0);
    do_reset();
    bitin(0, 1);
    chk("midrst_cnt", {24'd0, match_cnt}, 32'd0);
    stream(16'b1010, 4, 1, 0);
    chk("midrst_cnt2", {24'd0, match_cnt}, 32'd1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else if (r < 6) cfg(4'($urandom), 3'($urandom));
      else step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                0, 4'd0, 3'd0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
